// File: rtl/writeback_stage_n.sv
// writeback_stage_n
// Writeback stage between the memory stage and the register file / commit port.
// Captures up to LANES results per cycle into a single holding register, holds
// them until the commit side accepts (valid/ready), drives regfile write enables
// with x0 and same-bundle WAW suppression, and counts retired instructions.
//
// Ports
//   clk, resetn     clock; synchronous active-low reset
//   in_valid        per-lane valid from the memory stage
//   in_regwrite     per-lane "writes rd"
//   in_dst, in_data per-lane rd / writedata (lane l at [l*W +: W])
//   in_ready        stage can accept a bundle this cycle
//   flush           discard the incoming bundle this cycle
//   commit_ready    commit side accepts the held bundle
//   out_valid/dst/data  held bundle (commit view and forwarding source)
//   wb_en/addr/data     regfile write port per lane
//   instret         retired-instruction count (wraps)
module writeback_stage_n #(
    parameter int LANES = 2,
    parameter int XLEN  = 64,
    parameter int REGW  = 5,
    parameter int CNTW  = 64
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES-1:0]        in_regwrite,
    input  logic [LANES*REGW-1:0]   in_dst,
    input  logic [LANES*XLEN-1:0]   in_data,
    output logic                    in_ready,
    input  logic                    flush,
    input  logic                    commit_ready,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES*REGW-1:0]   out_dst,
    output logic [LANES*XLEN-1:0]   out_data,
    output logic [LANES-1:0]        wb_en,
    output logic [LANES*REGW-1:0]   wb_addr,
    output logic [LANES*XLEN-1:0]   wb_data,
    output logic [CNTW-1:0]         instret
);

    logic [LANES-1:0]      heldValid;
    logic [LANES-1:0]      heldRegWrite;
    logic [LANES*REGW-1:0] heldDst;
    logic [LANES*XLEN-1:0] heldData;
    logic [CNTW-1:0]       instretCnt;

    logic            held;
    logic            fire;
    logic            load;
    logic [CNTW-1:0] laneCount;

    assign held     = |heldValid;
    assign fire     = held & commit_ready;
    // Ready while draining lets a new bundle replace the firing one with no bubble.
    assign in_ready = !held | commit_ready;
    assign load     = in_ready & (|in_valid) & !flush;

    // Number of valid lanes in the held bundle, including non-writing ones.
    always_comb begin
        laneCount = '0;
        for (int l = 0; l < LANES; l++) begin
            laneCount = laneCount + CNTW'(heldValid[l]);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            heldValid    <= '0;
            heldRegWrite <= '0;
            heldDst      <= '0;
            heldData     <= '0;
            instretCnt   <= '0;
        end else begin
            if (load) begin
                heldValid    <= in_valid;
                heldRegWrite <= in_regwrite;
                heldDst      <= in_dst;
                heldData     <= in_data;
            end else if (fire) begin
                // Only validity needs clearing; stale dst/data are masked by it.
                heldValid    <= '0;
            end
            if (fire) begin
                instretCnt <= instretCnt + laneCount;
            end
        end
    end

    // Per-lane write enable. A lane is shadowed when a younger valid writing lane
    // in the same bundle targets the same register, so only the youngest write lands.
    for (genvar gi = 0; gi < LANES; gi++) begin : genLane
        logic shadowed;

        always_comb begin
            shadowed = 1'b0;
            for (int m = gi + 1; m < LANES; m++) begin
                if (heldValid[m] && heldRegWrite[m] &&
                    (heldDst[m*REGW +: REGW] == heldDst[gi*REGW +: REGW])) begin
                    shadowed = 1'b1;
                end
            end
        end

        assign wb_en[gi] = fire & heldValid[gi] & heldRegWrite[gi] &
                           (heldDst[gi*REGW +: REGW] != '0) & !shadowed;
    end

    assign out_valid = heldValid;
    assign out_dst   = heldDst;
    assign out_data  = heldData;
    assign wb_addr   = heldDst;
    assign wb_data   = heldData;
    assign instret   = instretCnt;

endmodule

// File: tb/tb_writeback_stage_n.sv
// Testbench for writeback_stage_n (LANES=2, XLEN=64, REGW=5, CNTW=4).
// A vector table drives one cycle per entry with hand-derived in_ready/wb_en;
// a scoreboard queue holds the bundle expected in the stage and is compared
// against the forwarding/write outputs, with an independent instret tally.
module tb_writeback_stage_n;

    localparam int LANES = 2;
    localparam int XLEN  = 64;
    localparam int REGW  = 5;
    localparam int CNTW  = 4;

    logic                  clk;
    logic                  resetn;
    logic [LANES-1:0]      in_valid;
    logic [LANES-1:0]      in_regwrite;
    logic [LANES*REGW-1:0] in_dst;
    logic [LANES*XLEN-1:0] in_data;
    logic                  in_ready;
    logic                  flush;
    logic                  commit_ready;
    logic [LANES-1:0]      out_valid;
    logic [LANES*REGW-1:0] out_dst;
    logic [LANES*XLEN-1:0] out_data;
    logic [LANES-1:0]      wb_en;
    logic [LANES*REGW-1:0] wb_addr;
    logic [LANES*XLEN-1:0] wb_data;
    logic [CNTW-1:0]       instret;

    writeback_stage_n #(.LANES(LANES), .XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_regwrite(in_regwrite), .in_dst(in_dst), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .commit_ready(commit_ready),
        .out_valid(out_valid), .out_dst(out_dst), .out_data(out_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  rw;
        logic [4:0]  d0;
        logic [4:0]  d1;
        logic [63:0] x0;
        logic [63:0] x1;
        logic        fl;
        logic        cr;
        logic        expRdy;
        logic [1:0]  expWb;
    } vec_t;

    typedef struct {
        logic [1:0]   valid;
        logic [9:0]   dst;
        logic [127:0] data;
    } bundle_t;

    localparam int NVEC = 21;
    vec_t       tbl[NVEC];
    bundle_t    sb[$];
    logic [3:0] expInstret;
    int         checks;
    int         failures;

    function automatic vec_t mk(logic [1:0] v, logic [1:0] rw, logic [4:0] d0, logic [4:0] d1,
                                logic [63:0] x0, logic [63:0] x1, logic fl, logic cr,
                                logic expRdy, logic [1:0] expWb);
        vec_t t;
        t.v = v; t.rw = rw; t.d0 = d0; t.d1 = d1; t.x0 = x0; t.x1 = x1;
        t.fl = fl; t.cr = cr; t.expRdy = expRdy; t.expWb = expWb;
        return t;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic driveIdle(input logic cr);
        in_valid = '0; in_regwrite = '0; in_dst = '0; in_data = '0;
        flush = 1'b0; commit_ready = cr;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        expInstret = '0;

        //                v      rw     d0  d1  x0     x1     fl  cr  rdy wb
        tbl[0]  = mk(2'b11, 2'b11, 5,  6,  'h11,  'h22,  0,  1,  1, 2'b00); // load A
        tbl[1]  = mk(2'b00, 2'b00, 0,  0,  0,     0,     0,  1,  1, 2'b11); // A writes x5/x6
        tbl[2]  = mk(2'b11, 2'b11, 8,  9,  'h33,  'h44,  0,  0,  1, 2'b00); // load B
        tbl[3]  = mk(2'b11, 2'b11, 10, 11, 'h55,  'h66,  0,  0,  0, 2'b00); // stall 1
        tbl[4]  = mk(2'b11, 2'b11, 10, 11, 'h55,  'h66,  0,  0,  0, 2'b00); // stall 2
        tbl[5]  = mk(2'b11, 2'b11, 10, 11, 'h55,  'h66,  0,  0,  0, 2'b00); // stall 3
        tbl[6]  = mk(2'b11, 2'b11, 10, 11, 'h55,  'h66,  0,  1,  1, 2'b11); // B fires, C loads
        tbl[7]  = mk(2'b11, 2'b11, 7,  7,  'hA,   'hB,   0,  1,  1, 2'b11); // C fires, WAW D loads
        tbl[8]  = mk(2'b11, 2'b01, 0,  12, 'h77,  'h88,  0,  1,  1, 2'b10); // D: only lane1
        tbl[9]  = mk(2'b11, 2'b11, 13, 14, 'hC1,  'hC2,  1,  1,  1, 2'b00); // E fires (x0/no-rw), flush F
        tbl[10] = mk(2'b00, 2'b00, 0,  0,  0,     0,     0,  1,  1, 2'b00); // empty after flush
        tbl[11] = mk(2'b11, 2'b11, 13, 14, 'hC1,  'hC2,  1,  0,  1, 2'b00); // flush while empty
        tbl[12] = mk(2'b01, 2'b11, 15, 15, 'h99,  'hAA,  0,  0,  1, 2'b00); // lane1 invalid
        tbl[13] = mk(2'b00, 2'b00, 0,  0,  0,     0,     0,  1,  1, 2'b01); // lane0 not shadowed
        tbl[14] = mk(2'b11, 2'b11, 17, 18, 'hD1,  'hD2,  0,  0,  1, 2'b00);
        tbl[15] = mk(2'b00, 2'b00, 0,  0,  0,     0,     0,  1,  1, 2'b11);
        tbl[16] = mk(2'b11, 2'b01, 19, 19, 'hE1,  'hE2,  0,  0,  1, 2'b00); // same rd, lane1 no rw
        tbl[17] = mk(2'b00, 2'b00, 0,  0,  0,     0,     0,  1,  1, 2'b01);
        tbl[18] = mk(2'b11, 2'b11, 21, 22, 'hF1,  'hF2,  0,  1,  1, 2'b00);
        tbl[19] = mk(2'b00, 2'b00, 0,  0,  0,     0,     0,  1,  1, 2'b11); // 15 + 2 wraps to 1
        tbl[20] = mk(2'b00, 2'b00, 0,  0,  0,     0,     0,  1,  1, 2'b00);

        // Reset
        resetn = 1'b0;
        driveIdle(1'b0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_wb_en", 128'(wb_en), 128'(0));
        chk("rst_instret", 128'(instret), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        $display("reset: out_valid=%b wb_en=%b instret=%0d in_ready=%b", out_valid, wb_en, instret, in_ready);
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            logic held;
            bundle_t nb;
            in_valid     = tbl[i].v;
            in_regwrite  = tbl[i].rw;
            in_dst       = {tbl[i].d1, tbl[i].d0};
            in_data      = {tbl[i].x1, tbl[i].x0};
            flush        = tbl[i].fl;
            commit_ready = tbl[i].cr;
            @(negedge clk);
            held = (sb.size() > 0);
            chk($sformatf("v%0d_in_ready", i), 128'(in_ready), 128'(tbl[i].expRdy));
            chk($sformatf("v%0d_wb_en", i), 128'(wb_en), 128'(tbl[i].expWb));
            chk($sformatf("v%0d_instret", i), 128'(instret), 128'(expInstret));
            if (held) begin
                chk($sformatf("v%0d_out_valid", i), 128'(out_valid), 128'(sb[0].valid));
                chk($sformatf("v%0d_out_dst", i), 128'(out_dst), 128'(sb[0].dst));
                chk($sformatf("v%0d_out_data", i), out_data, sb[0].data);
                if (tbl[i].cr) begin
                    chk($sformatf("v%0d_wb_addr", i), 128'(wb_addr), 128'(sb[0].dst));
                    chk($sformatf("v%0d_wb_data", i), wb_data, sb[0].data);
                    expInstret = expInstret + 4'(sb[0].valid[0]) + 4'(sb[0].valid[1]);
                    void'(sb.pop_front());
                end
            end else begin
                chk($sformatf("v%0d_out_valid_empty", i), 128'(out_valid), 128'(0));
            end
            if ((!held || tbl[i].cr) && (|tbl[i].v) && !tbl[i].fl) begin
                nb.valid = tbl[i].v;
                nb.dst   = {tbl[i].d1, tbl[i].d0};
                nb.data  = {tbl[i].x1, tbl[i].x0};
                sb.push_back(nb);
            end
            $display("vec %0d: in_ready=%b wb_en=%b wb_addr=%h out_valid=%b instret=%0d",
                     i, in_ready, wb_en, wb_addr, out_valid, instret);
            @(posedge clk);
            #1;
        end

        // Reset while a bundle is stalled: dropped with no write and no count.
        in_valid = 2'b11; in_regwrite = 2'b11; in_dst = {5'd24, 5'd23};
        in_data = {64'h1234, 64'h5678}; flush = 1'b0; commit_ready = 1'b0;
        @(posedge clk);
        #1 driveIdle(1'b0);
        @(negedge clk);
        chk("stall_out_valid", 128'(out_valid), 128'(2'b11));
        chk("stall_in_ready", 128'(in_ready), 128'(0));
        resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        commit_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_wb_en", 128'(wb_en), 128'(0));
        chk("midrst_instret", 128'(instret), 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_instret_after", 128'(instret), 128'(0));
        $display("reset mid-stall: out_valid=%b wb_en=%b instret=%0d", out_valid, wb_en, instret);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
